// File: rtl/gmii_rx_frame_if.sv
// gmii_rx_frame_if: received frame byte stream with first/last markers and {giant, runt, crc} flags.
interface gmii_rx_frame_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_sof;
    logic       rx_eof;
    logic [2:0] rx_err;
    modport master (output rx_data, rx_valid, rx_sof, rx_eof, rx_err);
    modport slave  (input  rx_data, rx_valid, rx_sof, rx_eof, rx_err);
endinterface

// File: rtl/gmii_rx_frame.sv
// gmii_rx_frame: GMII receive framer - preamble/SFD strip, DA filter, FCS strip, runt/giant/CRC flags.
// Define GMII_RX_FRAME_CRC_CHECK_EN to enable the CRC-32 check; otherwise the crc flag is always 0.
module gmii_rx_frame #(
    parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_01_02_03,
    parameter int          MAX_LEN   = 1518
) (
    input  logic            clk_125m,
    input  logic            rst_n,
    input  logic [7:0]      gmii_rxd,
    input  logic            gmii_rxdv,
    gmii_rx_frame_if.master rx,
    output logic [15:0]     frame_ok_cnt,
    output logic [15:0]     frame_bad_cnt
);
    typedef enum logic [2:0] {WAIT, IDLE, PRE, DATA, DROP} state_t;
    state_t      state, state_n;
    logic [39:0] dl;
    logic [2:0]  fill;
    logic [10:0] len;
    logic        acc;
    logic        cap, fall, full, da_hit, acc_now, emit, eof, crc_bad;
    logic [47:0] da;
    logic [2:0]  err;
    always_comb begin
        state_n = state;
        case (state)
            WAIT:    state_n = gmii_rxdv ? WAIT : IDLE;
            IDLE:    state_n = !gmii_rxdv ? IDLE : gmii_rxd == 8'h55 ? PRE : DROP;
            PRE:     state_n = !gmii_rxdv ? IDLE : gmii_rxd == 8'h55 ? PRE : gmii_rxd == 8'hD5 ? DATA : DROP;
            DATA:    state_n = gmii_rxdv ? DATA : IDLE;
            DROP:    state_n = gmii_rxdv ? DROP : IDLE;
            default: state_n = WAIT;
        endcase
    end
    // The five buffered bytes plus the incoming one form the complete DA at the sixth byte.
    assign cap     = state == DATA && gmii_rxdv;
    assign fall    = state == DATA && !gmii_rxdv;
    assign full    = fill == 3'd5;
    assign da      = {dl, gmii_rxd};
    assign da_hit  = da == LOCAL_MAC || da == '1;
    assign acc_now = len == 11'd5 ? da_hit : acc;
    assign emit    = full && (cap ? acc_now : acc);
    assign eof     = fall && emit;
    assign err     = {int'(len) > MAX_LEN, len < 11'd64, crc_bad};
    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            state         <= WAIT;
            dl            <= '0;
            fill          <= '0;
            len           <= '0;
            acc           <= 1'b0;
            rx.rx_valid   <= 1'b0;
            rx.rx_data    <= '0;
            rx.rx_sof     <= 1'b0;
            rx.rx_eof     <= 1'b0;
            rx.rx_err     <= '0;
            frame_ok_cnt  <= '0;
            frame_bad_cnt <= '0;
        end else begin
            state       <= state_n;
            dl          <= cap ? {dl[31:0], gmii_rxd} : '0;
            fill        <= cap ? fill + {2'b0, !full} : '0;
            len         <= cap ? len + {10'b0, len != 11'h7FF} : '0;
            acc         <= cap && acc_now;
            rx.rx_valid <= emit;
            rx.rx_data  <= emit ? dl[39:32] : '0;
            rx.rx_sof   <= emit && cap && len == 11'd5;
            rx.rx_eof   <= eof;
            rx.rx_err   <= eof ? err : '0;
            if (eof && err == '0)
                frame_ok_cnt <= frame_ok_cnt + 16'd1;
            if (fall && (len < 11'd6 || (eof && err != '0)))
                frame_bad_cnt <= frame_bad_cnt + 16'd1;
        end
    end
`ifdef GMII_RX_FRAME_CRC_CHECK_EN
    logic [31:0] crc;
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
        return r;
    endfunction
    // Running the register over the FCS too leaves the fixed residue on a good frame.
    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n)
            crc <= '1;
        else
            crc <= cap ? crc_byte(crc, gmii_rxd) : '1;
    end
    assign crc_bad = crc != 32'hDEBB20E3;
`else
    assign crc_bad = 1'b0;
`endif
endmodule

// File: tb/tb_gmii_rx_frame.sv
// tb_gmii_rx_frame: directed GMII frames; expected rx stream bytes queued at drive time, popped by a monitor.
module tb_gmii_rx_frame;
    localparam logic [47:0] MAC = 48'h00_0A_35_01_02_03;
`ifdef GMII_RX_FRAME_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif
    logic        clk_125m = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  gmii_rxd = '0;
    logic        gmii_rxdv = 1'b0;
    logic [15:0] frame_ok_cnt, frame_bad_cnt;
    gmii_rx_frame_if rx_if ();
    gmii_rx_frame dut (
        .clk_125m(clk_125m),
        .rst_n(rst_n),
        .gmii_rxd(gmii_rxd),
        .gmii_rxdv(gmii_rxdv),
        .rx(rx_if),
        .frame_ok_cnt(frame_ok_cnt),
        .frame_bad_cnt(frame_bad_cnt)
    );
    always #4 clk_125m = ~clk_125m;

    int          checks = 0, passed = 0, fails = 0;
    logic [7:0]  frm[$];
    logic [12:0] sb[$];
    logic [15:0] exp_ok = '0, exp_bad = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Every negedge: a valid byte must match the queue head, otherwise all stream outputs are 0.
    always @(negedge clk_125m) begin : mon
        logic [12:0] obs;
        obs = {rx_if.rx_data, rx_if.rx_sof, rx_if.rx_eof, rx_if.rx_err};
        if (rx_if.rx_valid !== 1'b1)
            check("idle_outputs_zero", {18'd0, rx_if.rx_valid, obs}, 32'd0);
        else if (sb.size() == 0)
            check("spurious_rx_valid", {31'd0, rx_if.rx_valid}, 32'd0);
        else
            check("rx_byte", {19'd0, obs}, {19'd0, sb.pop_front()});
    end

    task automatic drv(input logic [7:0] b, input logic v);
        @(posedge clk_125m);
        #1;
        gmii_rxd  = v ? b : 8'h00;
        gmii_rxdv = v;
    endtask

    task automatic build(input logic [47:0] da, input int len, input bit flip);
        logic [31:0] c;
        frm.delete();
        for (int i = 0; i < 6 && i < len; i++) frm.push_back(da[47 - 8*i -: 8]);
        for (int i = 6; i < len - 4; i++) frm.push_back(8'(i * 7 + 3));
        if (len >= 10) begin
            c = '1;
            foreach (frm[k])
                for (int j = 0; j < 8; j++)
                    c = (c >> 1) ^ ((c[0] ^ frm[k][j]) ? 32'hEDB88320 : 32'h0);
            c = ~c;
            for (int j = 0; j < 4; j++) frm.push_back(c[8*j +: 8]);
            if (flip) frm[20] = frm[20] ^ 8'h10;
        end
    endtask

    task automatic predict(input bit acc, input bit crc_err);
        int n;
        logic [2:0] err;
        n = frm.size();
        err = {n > 1518, n < 64, crc_err && CRC_EN};
        if (n < 6) exp_bad++;
        else if (acc) begin
            for (int i = 0; i <= n - 5; i++)
                sb.push_back({frm[i], i == 0, i == n - 5, (i == n - 5) ? err : 3'b000});
            if (err == 3'b000) exp_ok++;
            else exp_bad++;
        end
    endtask

    task automatic preamble();
        for (int i = 0; i < 7; i++) drv(8'h55, 1'b1);
        drv(8'hD5, 1'b1);
    endtask

    task automatic send(input int idle);
        preamble();
        foreach (frm[i]) drv(frm[i], 1'b1);
        repeat (idle) drv(8'h00, 1'b0);
    endtask

    task automatic check_cnt(input string tag);
        check({tag, "_ok_cnt"}, {16'd0, frame_ok_cnt}, {16'd0, exp_ok});
        check({tag, "_bad_cnt"}, {16'd0, frame_bad_cnt}, {16'd0, exp_bad});
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #20;
        check("reset_rx_valid", {31'd0, rx_if.rx_valid}, 32'd0);
        check_cnt("reset");
        rst_n = 1'b1;
        repeat (2) drv(8'h00, 1'b0);
        build(MAC, 64, 1'b0); predict(1'b1, 1'b0); send(4); check_cnt("good64");
        build(MAC, 64, 1'b1); predict(1'b1, 1'b1); send(4); check_cnt("crc_flip");
        build(48'h02_00_00_00_00_01, 64, 1'b0); predict(1'b0, 1'b0); send(4); check_cnt("da_reject");
        build(48'hFFFF_FFFF_FFFF, 64, 1'b0); predict(1'b1, 1'b0); send(4); check_cnt("broadcast");
        build(MAC, 40, 1'b0); predict(1'b1, 1'b0); send(4); check_cnt("runt40");
        build(MAC, 1600, 1'b0); predict(1'b1, 1'b0); send(4); check_cnt("giant1600");
        build(MAC, 3, 1'b0); predict(1'b1, 1'b0); send(4); check_cnt("tiny3");
        repeat (10) drv(8'hAA, 1'b1);
        repeat (2) drv(8'h00, 1'b0);
        check_cnt("idle_drop");
        repeat (3) drv(8'h55, 1'b1);
        repeat (2) drv(8'h00, 1'b0);
        check_cnt("pre_abort");
        // Bytes 0..13 reach the monitor before reset lands while byte 20 is on the wire.
        build(MAC, 64, 1'b0);
        for (int i = 0; i < 14; i++) sb.push_back({frm[i], i == 0, 1'b0, 3'b000});
        preamble();
        for (int i = 0; i < 21; i++) drv(frm[i], 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_rx_valid", {31'd0, rx_if.rx_valid}, 32'd0);
        check("rst_mid_rx_eof", {31'd0, rx_if.rx_eof}, 32'd0);
        exp_ok = '0;
        exp_bad = '0;
        check_cnt("rst_mid");
        #2 rst_n = 1'b1;
        for (int i = 21; i < 64; i++) drv(frm[i], 1'b1);
        repeat (3) drv(8'h00, 1'b0);
        check_cnt("after_rst");
        build(MAC, 64, 1'b0); predict(1'b1, 1'b0); send(4); check_cnt("resume");
        predict(1'b1, 1'b0); send(1);
        predict(1'b1, 1'b0); send(4);
        check_cnt("back_to_back");
        repeat (8) drv(8'h00, 1'b0);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
